// File: rtl/dmem_lsu_hs_if.sv
// Load/store request and response handshake bundle for dmem_lsu_hs.
// The master is the requesting pipeline stage and the slave is the memory.
interface dmem_lsu_hs_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lsu_hs.sv
// Single-port data memory with a valid/ready load/store handshake, wait states, byte lanes and
// RV32 load extension. Define MISALIGN_TRAP_EN to report misaligned H/W accesses as errors.
module dmem_lsu_hs #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  dmem_lsu_hs_if.slave bus
);
  localparam int              IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * DEPTH_WORDS);
  localparam logic [3:0]      WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [3:0]        wait_cnt_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [2:0]        funct3_r;
  logic              req_ready_r, resp_valid_r, resp_err_r;
  logic [31:0]       resp_rdata_r;
  logic [31:0]       mem_r [DEPTH_WORDS];

  logic              accept_s, misalign_s, err_s;
  logic [IDX_W-1:0]  idx_s;
  logic [3:0]        be_s;
  logic [31:0]       wword_s, rword_s, ldata_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return !we;
      default:                return 1'b0;
    endcase
  endfunction

  assign accept_s = bus.req_valid && req_ready_r;
  assign idx_s    = addr_r[IDX_W+1:2];
  assign rword_s  = mem_r[idx_s];

`ifdef MISALIGN_TRAP_EN
  assign misalign_s = ((funct3_r[1:0] == 2'b01) && addr_r[0]) ||
                      ((funct3_r[1:0] == 2'b10) && (addr_r[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign err_s = ({1'b0, addr_r} >= ADDR_LIMIT) || !funct3_legal(we_r, funct3_r) || misalign_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:   if (accept_s) state_s = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                else          state_s = S_IDLE;
      S_WAIT:   if (wait_cnt_r == 4'd0) state_s = S_ACCESS;
                else                    state_s = S_WAIT;
      S_ACCESS: state_s = S_RESP;
      S_RESP:   if (bus.resp_ready) state_s = S_IDLE;
                else                state_s = S_RESP;
      default:  state_s = S_IDLE;
    endcase
  end

  // Lane steering: store byte enables / replicated data and extended load data
  always_comb begin
    be_s    = 4'b0000;
    wword_s = wdata_r;
    byte_s  = rword_s[{addr_r[1:0], 3'b000} +: 8];
    half_s  = addr_r[1] ? rword_s[31:16] : rword_s[15:0];
    ldata_s = 32'd0;
    case (funct3_r[1:0])
      2'b00: begin
        be_s    = 4'b0001 << addr_r[1:0];
        wword_s = {4{wdata_r[7:0]}};
        ldata_s = funct3_r[2] ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      end
      2'b01: begin
        be_s    = addr_r[1] ? 4'b1100 : 4'b0011;
        wword_s = {2{wdata_r[15:0]}};
        ldata_s = funct3_r[2] ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      end
      2'b10: begin
        be_s    = 4'b1111;
        ldata_s = rword_s;
      end
      default: begin
        be_s    = 4'b0000;
        ldata_s = 32'd0;
      end
    endcase
  end

  // Store commit on the edge leaving ACCESS; memory is deliberately not reset
  always_ff @(posedge clk) begin
    if ((state_r == S_ACCESS) && we_r && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) mem_r[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
      end
    end
  end

  // Request latch, wait counter and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_r  <= 1'b1;
      wait_cnt_r   <= 4'd0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= 32'd0;
      funct3_r     <= 3'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      req_ready_r <= (state_s == S_IDLE);
      if (accept_s) begin
        we_r       <= bus.req_we;
        addr_r     <= bus.req_addr;
        wdata_r    <= bus.req_wdata;
        funct3_r   <= bus.req_funct3;
        wait_cnt_r <= WAIT_LOAD;
      end else if ((state_r == S_WAIT) && (wait_cnt_r != 4'd0)) begin
        wait_cnt_r <= wait_cnt_r - 4'd1;
      end
      if (state_r == S_ACCESS) begin
        resp_valid_r <= 1'b1;
        resp_err_r   <= err_s;
        resp_rdata_r <= (!we_r && !err_s) ? ldata_s : 32'd0;
      end else if ((state_r == S_RESP) && bus.resp_ready) begin
        resp_valid_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;
endmodule

// File: tb/tb_dmem_lsu_hs.sv
// Scoreboard bench for dmem_lsu_hs: a byte-addressed reference memory predicts each response,
// and an independent monitor checks responses, latency, hold-stability and req_ready.
module tb_dmem_lsu_hs;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
  localparam int WAITC  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_lsu_hs_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_lsu_hs #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem_m [0:4*DEPTH-1];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         bp_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed memory, access size from funct3, natural alignment by rounding down
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [2:0] f3, output logic [31:0] rd, output logic err);
    int unsigned size, base;
    logic [31:0] v;
    size = 1 << f3[1:0];
    err  = (addr >= 32'(4 * DEPTH));
    if (we) err = err | (f3 > 3'd2);
    else    err = err | !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MISALIGN_TRAP_EN
    if ((addr % size) != 0) err = 1'b1;
`endif
    rd = 32'd0;
    if (err) return;
    base = addr - (addr % size);
    if (we) begin
      for (int i = 0; i < int'(size); i++) mem_m[base + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < int'(size); i++) v[8*i +: 8] = mem_m[base + i];
      if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      rd = v;
    end
  endfunction

  // Called at a negedge; returns at the negedge after the request was accepted
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input bit track);
    exp_t e;
    logic [31:0] rd;
    logic err;
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_funct3 = f3;
    if (track) begin
      model(we, addr, wd, f3, rd, err);
      e.rd  = rd;
      e.err = err;
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on each new response and drives resp_ready
  initial begin
    exp_t cur;
    bit seen = 1'b0;
    bit post = 1'b0;
    cur.rd = 32'd0; cur.err = 1'b0; cur.acc = 0;
    bus.resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
        post = 1'b0;
        bus.resp_ready = 1'b0;
      end else if (bus.resp_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            chk("unexpected_resp", 32'(q.size()), 32'd1);
          end else begin
            cur = q.pop_front();
            chk("latency", 32'(cyc - cur.acc), 32'(WAITC + 1));
          end
          seen = 1'b1;
        end
        chk("rdata", bus.resp_rdata, cur.rd);
        chk("err", 32'(bus.resp_err), 32'(cur.err));
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
        if (bp_hold > 0) begin
          bus.resp_ready = 1'b0;
          bp_hold--;
        end else begin
          bus.resp_ready = ($urandom_range(0, 2) != 0);
        end
        if (bus.resp_ready) begin
          seen = 1'b0;
          post = 1'b1;
        end
      end else begin
        if (post) chk("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
        post = 1'b0;
        bus.resp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.resp_valid === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_funct3 = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset_resp_rdata", bus.resp_rdata, 32'd0);
    chk("reset_resp_err", 32'(bus.resp_err), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 3'd2, 1'b1);
    drain();

    // Reset in the middle of WAIT drops the store and its response
    issue(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b0, 32'h10, 32'd0, 3'd2, 1'b1);

    issue(1'b1, 32'h20, 32'h8000_00FF, 3'd2, 1'b1);
    issue(1'b0, 32'h20, 32'd0, 3'd2, 1'b1);

    issue(1'b1, 32'h20, 32'h0000_0000, 3'd2, 1'b1);
    issue(1'b1, 32'h23, 32'h0000_0080, 3'd0, 1'b1);
    issue(1'b0, 32'h23, 32'd0, 3'd0, 1'b1);
    issue(1'b0, 32'h23, 32'd0, 3'd4, 1'b1);
    issue(1'b0, 32'h20, 32'd0, 3'd2, 1'b1);

    issue(1'b1, 32'h42, 32'h0000_9ABC, 3'd1, 1'b1);
    issue(1'b0, 32'h42, 32'd0, 3'd1, 1'b1);
    issue(1'b0, 32'h42, 32'd0, 3'd5, 1'b1);
    issue(1'b0, 32'h40, 32'd0, 3'd2, 1'b1);

    issue(1'b0, 32'(4 * DEPTH), 32'd0, 3'd2, 1'b1);
    issue(1'b0, 32'hFFFF_FFF0, 32'd0, 3'd2, 1'b1);
    issue(1'b1, 32'(4 * DEPTH), 32'h1234_5678, 3'd2, 1'b1);
    issue(1'b1, 32'h24, 32'h0000_0055, 3'd4, 1'b1);
    issue(1'b0, 32'h24, 32'd0, 3'd2, 1'b1);
    issue(1'b0, 32'h22, 32'd0, 3'd2, 1'b1);
    issue(1'b0, 32'h21, 32'd0, 3'd1, 1'b1);
    issue(1'b0, 32'h20, 32'd0, 3'd3, 1'b1);
    issue(1'b0, 32'h20, 32'd0, 3'd6, 1'b1);
    issue(1'b0, 32'h20, 32'd0, 3'd7, 1'b1);
    issue(1'b1, 32'h20, 32'hFFFF_FFFF, 3'd5, 1'b1);
    issue(1'b0, 32'h20, 32'd0, 3'd2, 1'b1);
    drain();

    // Backpressure: hold the response for five cycles with a second request queued behind it
    bp_hold = 5;
    issue(1'b0, 32'h40, 32'd0, 3'd2, 1'b1);
    issue(1'b0, 32'h20, 32'd0, 3'd2, 1'b1);
    drain();

    repeat (300) begin
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 4 * DEPTH + 31)), $urandom,
            3'($urandom_range(0, 7)), 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
